// File: rtl/flex_serial_adder.sv
// Multi-cycle adder that sums two WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
// Results are registered and held until the next operation completes.
module flex_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BaseW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic [BaseW-1:0] base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    base      = BaseW'(idx_q * CHUNK);
    a_chunk   = a_q[base +: CHUNK];
    b_chunk   = b_q[base +: CHUNK];
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StAdd;
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          acc_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StAdd: begin
        acc_d[base +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d              = chunk_res[CHUNK];
        idx_d                = idx_q + IdxW'(1);
        // Final chunk: publish all three results on the same edge.
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
          sum_d   = acc_d;
          cout_d  = chunk_res[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == StAdd);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_flex_serial_adder.sv
// Self-checking bench for flex_serial_adder: directed table, corner sequences, random ops
// against an arithmetic model, and exhaustive 4-bit sweeps for CHUNK = 1, 2 and 4.
module tb_flex_serial_adder;

  localparam int unsigned W = 16;
  localparam int unsigned C = 4;
  localparam int unsigned N = W / C;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          carry_in;
  logic [W-1:0]  sum;
  logic          carry_out;
  logic          overflow;
  logic          busy;
  logic          done;

  logic          s_start;
  logic [3:0]    sa;
  logic [3:0]    sb;
  logic          sc;
  logic [3:0]    s_sum  [3];
  logic          s_co   [3];
  logic          s_ov   [3];
  logic          s_busy [3];
  logic          s_done [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flex_serial_adder #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  for (genvar g = 0; g < 3; g++) begin : g_small
    localparam int unsigned Ch = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    flex_serial_adder #(
      .WIDTH(4),
      .CHUNK(Ch)
    ) u_dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (s_start),
      .a        (sa),
      .b        (sb),
      .carry_in (sc),
      .sum      (s_sum[g]),
      .carry_out(s_co[g]),
      .overflow (s_ov[g]),
      .busy     (s_busy[g]),
      .done     (s_done[g])
    );
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {overflow, carry_out, sum} straight from integer addition.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    logic [16:0] t;
    logic        ov;
    t  = {1'b0, x} + {1'b0, y} + 17'(ci);
    ov = (x[15] == y[15]) && (t[15] != x[15]);
    return {ov, t};
  endfunction

  // Launches one op and returns the cycle count until done plus the number of busy cycles.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        input bit scramble, output int lat, output int nbusy);
    logic [15:0] held;
    bit          held_ok;
    held     = sum;
    held_ok  = 1'b1;
    a        = x;
    b        = y;
    carry_in = ci;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nbusy++;
      if (sum !== held) held_ok = 1'b0;
      if (scramble) begin
        a        = 16'($urandom);
        b        = 16'($urandom);
        carry_in = 1'($urandom);
        start    = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("hold_during_busy", 32'(held_ok), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          nb;
    int          dones;
    logic [17:0] r;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    int          lat_s [3];
    logic [4:0]  ref5;
    logic        rov;
    int          exp_n [3];

    vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    exp_n   = '{4, 2, 1};

    n_rst    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
    s_start  = 1'b0;
    sa       = '0;
    sb       = '0;
    sc       = 1'b0;
    #12;
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_carry_out", 32'(carry_out), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Start presented right at release must be taken on the first edge.
    @(negedge clk);
    n_rst = 1'b1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, nb);
    check("first_latency", 32'(lat), 32'(N));
    check("first_busy_cycles", 32'(nb), 32'(N));
    check("first_sum", 32'(sum), 32'h0002);
    check("first_carry", 32'(carry_out), 32'd0);
    check("first_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1, lat, nb);
      check("vec_latency", 32'(lat), 32'(N));
      check("vec_busy_cycles", 32'(nb), 32'(N));
      check("vec_sum", 32'(sum), 32'(vecs[i].s));
      check("vec_carry", 32'(carry_out), 32'(vecs[i].co));
      check("vec_ovf", 32'(overflow), 32'(vecs[i].ov));
      @(posedge clk); #1;
      check("vec_done_drop", 32'(done), 32'd0);
    end

    // Start pulsed mid-operation with different operands must be ignored.
    a = 16'h1234; b = 16'h1111; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        dones++;
        check("ignored_start_sum", 32'(sum), 32'h2345);
      end
      @(posedge clk); #1;
    end
    check("ignored_start_done_count", 32'(dones), 32'd1);

    // Back-to-back: start held through the done cycle.
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, nb);
    check("b2b_first_done", 32'(done), 32'd1);
    a = 16'h8000; b = 16'h8000; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_dropped", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_sum_held", 32'(sum), 32'h2345);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check("b2b_latency", 32'(lat), 32'(N));
    check("b2b_sum", 32'(sum), 32'h0000);
    check("b2b_carry", 32'(carry_out), 32'd1);
    check("b2b_ovf", 32'(overflow), 32'd1);

    // Reset mid-operation, with non-zero results still on the outputs.
    run_op(16'h8000, 16'h8001, 1'b0, 1'b0, lat, nb);
    check("pre_abort_sum", 32'(sum), 32'h0001);
    a = 16'h0101; b = 16'h0202; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 5 == 0) rb = ~ra;
      r = model(ra, rb, rc);
      run_op(ra, rb, rc, 1'b1, lat, nb);
      check("rand_latency", 32'(lat), 32'(N));
      check("rand_result", 32'({overflow, carry_out, sum}), 32'(r));
    end
    @(posedge clk); #1;

    for (int i = 0; i < 512; i++) begin
      sa      = 4'(i);
      sb      = 4'(i >> 4);
      sc      = 1'(i >> 8);
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      lat_s   = '{-1, -1, -1};
      for (int k = 0; k < 8; k++) begin
        for (int g = 0; g < 3; g++) begin
          if (s_done[g] && lat_s[g] < 0) lat_s[g] = k;
        end
        @(posedge clk); #1;
      end
      ref5 = {1'b0, sa} + {1'b0, sb} + 5'(sc);
      rov  = (sa[3] == sb[3]) && (ref5[3] != sa[3]);
      for (int g = 0; g < 3; g++) begin
        check("small_sum_carry", 32'({s_co[g], s_sum[g]}), 32'(ref5));
        check("small_ovf", 32'(s_ov[g]), 32'(rov));
        check("small_latency", 32'(lat_s[g]), 32'(exp_n[g]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
